// File: rtl/riscv_pkg.sv
// Shared constants and type encodings for the fetch front end.
package riscv_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  // Fetch controller states
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // Update action applied to the IF/ID register each cycle
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,  // keep contents
    IFID_LOAD   = 2'd1,  // capture a new valid instruction
    IFID_BUBBLE = 2'd2,  // clear valid only
    IFID_KILL   = 2'd3   // clear valid and force NOP (redirect)
  } ifid_op_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, bubble, kill and hold controls.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ifid_op_e    op,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_pc4,
  input  logic [31:0] d_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  // Select next register contents from the requested operation
  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (op)
      IFID_LOAD: begin
        pc_d    = d_pc;
        pc4_d   = d_pc4;
        instr_d = d_instr;
        valid_d = 1'b1;
      end
      IFID_BUBBLE: valid_d = 1'b0;
      IFID_KILL: begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
      default: ;
    endcase
  end

  // Register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign if_id_pc    = pc_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_instr = instr_q;
  assign if_id_valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: pc register, fetch FSM, one-entry hold buffer,
// and the IF/ID pipeline register.
module if_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        flush,
  input  logic        stall,
  output logic [31:0] pc4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redirect_q, redirect_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [31:0]  buf_instr_q, buf_instr_d;

  ifid_op_e     ifid_op;
  logic [31:0]  ifid_pc, ifid_pc4, ifid_instr;

  assign pc4       = pc_q + 32'd4;
  assign imem_addr = pc_q;

  // State, pc, redirect target and hold buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_VECTOR;
      redirect_q  <= '0;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redirect_q  <= redirect_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  // Next state, pc, redirect target and hold buffer
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redirect_d  = redirect_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    unique case (state_q)
      FETCH: begin
        if (flush) begin
          if (imem_ready) begin
            pc_d = next_pc;
          end else begin
            // keep pc so the outstanding address stays stable until it drains
            redirect_d = next_pc;
            state_d    = DISCARD;
          end
        end else if (imem_ready) begin
          if (stall) begin
            buf_pc_d    = pc_q;
            buf_instr_d = imem_rdata;
            state_d     = HOLD;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      HOLD: begin
        if (flush || !stall) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
        if (flush) begin
          buf_pc_d    = '0;
          buf_instr_d = '0;
        end
      end
      DISCARD: begin
        if (imem_ready) begin
          pc_d    = flush ? next_pc : redirect_q;
          state_d = FETCH;
        end else if (flush) begin
          redirect_d = next_pc;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Memory request and IF/ID update selection
  always_comb begin
    imem_req   = !rst && (state_q != HOLD);
    ifid_op    = IFID_HOLD;
    ifid_pc    = pc_q;
    ifid_pc4   = pc4;
    ifid_instr = imem_rdata;
    if (flush) begin
      ifid_op = IFID_KILL;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready && !stall) ifid_op = IFID_LOAD;
          else if (!imem_ready && !stall) ifid_op = IFID_BUBBLE;
        end
        HOLD: begin
          ifid_pc    = buf_pc_q;
          ifid_pc4   = buf_pc_q + 32'd4;
          ifid_instr = buf_instr_q;
          if (!stall) ifid_op = IFID_LOAD;
        end
        DISCARD: begin
          if (!stall) ifid_op = IFID_BUBBLE;
        end
        default: ;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .op          (ifid_op),
    .d_pc        (ifid_pc),
    .d_pc4       (ifid_pc4),
    .d_instr     (ifid_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid)
  );

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have ports: clk input 1, the single clock (all state on rising edge); rst input 1, synchronous active-high reset.
REQ-002 SHALL have next_pc input 32: next fetch address from the next-PC selector; flush input 1: redirect, the next_pc value is the redirect target.
REQ-003 SHALL have stall input 1: hold IF/ID (load-use hazard from ID).
REQ-004 SHALL have pc4 output 32: current fetch PC + 4, fed to the next-PC selector.
REQ-005 SHALL have imem_req output 1: fetch request; imem_addr output 32: fetch address; imem_rdata input 32: instruction word; imem_ready input 1: response valid and request accepted, in the same cycle.
REQ-006 SHALL have if_id_pc output 32, if_id_pc4 output 32, if_id_instr output 32 and if_id_valid output 1: the registered IF/ID payload.

Function
REQ-007 SHALL hold a 32-bit pc register; imem_addr = pc in FETCH; pc4 = pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
REQ-008 SHALL implement FSM states FETCH, HOLD, DISCARD; imem_req = 1 in FETCH/DISCARD, 0 in HOLD, and 0 while rst = 1.
REQ-009 Handshake: imem_addr SHALL stay stable while imem_req = 1 and imem_ready = 0; a transfer completes on a cycle with imem_req = imem_ready = 1; zero or more wait cycles allowed.
REQ-010 FETCH, ready=1, flush=0, stall=0: IF/ID <= {pc, pc4, imem_rdata, valid=1}; pc <= next_pc; stay FETCH.
REQ-011 FETCH, ready=1, flush=0, stall=1: SHALL capture {pc, imem_rdata} into a one-entry hold buffer; IF/ID held; pc held; go HOLD.
REQ-012 FETCH, ready=0, flush=0: stall=1 SHALL hold IF/ID; stall=0 SHALL load bubble (if_id_valid <= 0); pc held.
REQ-013 HOLD, flush=0, stall=0: IF/ID <= {buffered pc, buffered pc+4, buffered instr, valid=1}; pc <= next_pc; go FETCH. stall=1: hold everything.
REQ-014 Flush SHALL override stall in every state; on flush if_id_valid <= 0 and if_id_instr <= NOP (0x00000013).
REQ-015 Flush in FETCH with ready=1, or in HOLD: hold buffer is dropped; pc <= next_pc; go FETCH.
REQ-016 Flush in FETCH with ready=0: redirect_pc <= next_pc; pc held (address stable); go DISCARD.
REQ-017 DISCARD: response SHALL be dropped, never written to IF/ID. On ready=1: pc <= redirect_pc, or next_pc if flush is also asserted that cycle; go FETCH. On ready=0 with flush: redirect_pc <= next_pc (the latest flush wins).
REQ-018 Latency: an instruction returned with no stall SHALL appear on if_id_* the cycle after the ready edge; a back-to-back fetch with a zero-wait memory SHALL sustain 1 instruction/cycle.
REQ-019 if_id_pc4 SHALL always equal if_id_pc + 4 when if_id_valid = 1.

Reset
REQ-020 While rst = 1 at a clock edge: pc <= RESET_VECTOR (0x00000000), state <= FETCH, redirect_pc <= 0, hold buffer cleared.
REQ-021 While rst = 1 at a clock edge: if_id_valid <= 0, if_id_pc <= 0, if_id_pc4 <= 0, if_id_instr <= NOP.
REQ-022 Reset asserted mid-transfer (FETCH waiting, HOLD or DISCARD) SHALL abandon the transfer; the first request after reset SHALL be to RESET_VECTOR.

Structure
REQ-023 RESET_VECTOR, NOP_INSTR and the FSM state encodings SHALL live in the shared riscv_pkg constants file.
REQ-024 The IF/ID register (load, bubble and hold controls) SHALL be a sub-module if_id_reg; the FSM, pc and hold buffer SHALL stay in if_stage.

Verification
REQ-025 Reset, then zero-wait memory returning 0x00500093 at 0x0; next_pc = pc4 -> imem_addr goes 0x0, 0x4, 0x8 on consecutive cycles; if_id_pc = 0x0, if_id_instr = 0x00500093, valid = 1 one cycle after.
REQ-026 ready held 0 for 3 cycles at pc = 0x10 -> imem_addr remains 0x10 throughout; if_id_valid = 0 during the wait; instruction issues on the 4th cycle.
REQ-027 stall = 1 for 2 cycles while the instruction at 0x20 returns -> FSM enters HOLD with imem_req = 0; after release, if_id_pc = 0x20 and pc = 0x24.
REQ-028 Flush to 0x100 while 0x30 is outstanding (ready = 0), 0x30's data returns 2 cycles later -> 0x30's data is never valid on IF/ID; the next imem_addr is 0x100.
REQ-029 flush = 1 and stall = 1 in the same cycle in HOLD -> buffer dropped; if_id_valid = 0, if_id_instr = 0x00000013; imem_addr = next_pc on the next cycle.
REQ-030 pc = 0xFFFFFFFC -> pc4 = 0x00000000; rst pulsed during DISCARD -> next request at 0x0 with if_id_valid = 0.
